mem_access_unit: RTL and testbench

//  Memory stage. Consumes the EX/MEM pipeline register outputs, runs one data-cache transaction per

---
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit.sv | 119 +++++++++++
 tb/tb_mem_access_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-cache request/response bus between the memory stage and the D-cache.
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                    dc_req_valid;
  logic                    dc_req_ready;
  logic [ADDR_WIDTH-1:0]   dc_addr;
  logic                    dc_we;
  logic [DATA_WIDTH-1:0]   dc_wdata;
  logic [DATA_WIDTH/8-1:0] dc_byte_en;
  logic                    dc_resp_valid;
  logic [DATA_WIDTH-1:0]   dc_rdata;

  modport master (
    output dc_req_valid, dc_addr, dc_we, dc_wdata, dc_byte_en,
    input  dc_req_ready, dc_resp_valid, dc_rdata
  );
  modport slave (
    input  dc_req_valid, dc_addr, dc_we, dc_wdata, dc_byte_en,
    output dc_req_ready, dc_resp_valid, dc_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: one D-cache transaction per load/store, stalling the pipeline until done.
module mem_access_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_mem_access,
  input  logic                  i_mem_we,
  input  logic [2:0]            i_func3,
  input  logic [ADDR_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output logic                  o_stall_mem,
  output logic                  o_misaligned,
  output logic [DATA_WIDTH-1:0] o_read_data,
  mem_access_unit_if.master     dc
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                  state, state_n;
  logic                    aligned, accept;
  logic [7:0]              size_mask;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [7:0]              be_q;
  logic [2:0]              func3_q;
  logic [2:0]              off_q;
  logic [DATA_WIDTH-1:0]   shifted, ext;

  always_comb begin
    aligned   = 1'b1;
    size_mask = 8'h01;
    case (i_func3[1:0])
      2'b00: begin aligned = 1'b1;                      size_mask = 8'h01; end
      2'b01: begin aligned = ~i_alu_result[0];          size_mask = 8'h03; end
      2'b10: begin aligned = (i_alu_result[1:0] == 2'b0); size_mask = 8'h0F; end
      default: begin aligned = (i_alu_result[2:0] == 3'b0); size_mask = 8'hFF; end
    endcase
    if (i_func3 == 3'b111) aligned = 1'b0;
  end

  always_comb begin
    state_n      = state;
    o_stall_mem  = 1'b0;
    o_misaligned = 1'b0;
    accept       = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_mem_access) begin
          if (aligned) begin
            accept      = 1'b1;
            o_stall_mem = 1'b1;
            state_n     = S_REQ;
          end else begin
            o_misaligned = 1'b1;
          end
        end
      end
      S_REQ: begin
        o_stall_mem = 1'b1;
        if (dc.dc_req_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        o_stall_mem = 1'b1;
        if (dc.dc_resp_valid) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state <= S_IDLE;
    else        state <= state_n;
  end

  // Bring the addressed lane down to bit 0, then extend per size/sign
  always_comb begin
    shifted = dc.dc_rdata >> {off_q, 3'b000};
    case (func3_q)
      3'b000:  ext = {{(DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
      3'b001:  ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b010:  ext = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
      3'b100:  ext = {{(DATA_WIDTH-8){1'b0}},         shifted[7:0]};
      3'b101:  ext = {{(DATA_WIDTH-16){1'b0}},        shifted[15:0]};
      3'b110:  ext = {{(DATA_WIDTH-32){1'b0}},        shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      func3_q     <= '0;
      off_q       <= '0;
      o_read_data <= '0;
    end else begin
      if (accept) begin
        addr_q  <= {i_alu_result[ADDR_WIDTH-1:3], 3'b000};
        we_q    <= i_mem_we;
        wdata_q <= i_write_data << {i_alu_result[2:0], 3'b000};
        be_q    <= size_mask << i_alu_result[2:0];
        func3_q <= i_func3;
        off_q   <= i_alu_result[2:0];
      end
      if (state == S_WAIT && dc.dc_resp_valid && !we_q) o_read_data <= ext;
    end
  end

  assign dc.dc_req_valid = (state == S_REQ);
  assign dc.dc_addr      = addr_q;
  assign dc.dc_we        = we_q;
  assign dc.dc_wdata     = wdata_q;
  assign dc.dc_byte_en   = be_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, reset/backpressure sequences, random vs. model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        arst;
  logic        mem_access, mem_we;
  logic [2:0]  func3;
  logic [63:0] alu_result, write_data;
  logic        stall, misal;
  logic [63:0] read_data;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dcif ();

  mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .i_clk(clk), .i_arst(arst), .i_mem_access(mem_access), .i_mem_we(mem_we),
    .i_func3(func3), .i_alu_result(alu_result), .i_write_data(write_data),
    .o_stall_mem(stall), .o_misaligned(misal), .o_read_data(read_data),
    .dc(dcif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] addr;
    logic        we;
    logic [63:0] wd;
    logic [63:0] rdata;
    int          rdy;
    int          rsp;
    logic        mis;
    logic [7:0]  be;
    logic [63:0] ewd;
    logic [63:0] erd;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: byte-wise extraction and arithmetic extension
  function automatic vec_t model(input logic [2:0] f3, input logic [63:0] addr, input logic we,
                                 input logic [63:0] wd, input logic [63:0] rdata,
                                 input logic [63:0] prev_rd);
    vec_t v;
    int nb, off;
    logic [63:0] val;
    logic [15:0] m;
    nb  = 1 << f3[1:0];
    off = int'(addr % 8);
    v.f3 = f3; v.addr = addr; v.we = we; v.wd = wd; v.rdata = rdata;
    v.rdy = 0; v.rsp = 0;
    v.mis = (f3 == 3'b111) || ((addr % nb) != 0);
    m     = 16'((1 << nb) - 1) << off;
    v.be  = m[7:0];
    v.ewd = wd << (8 * off);
    val = 64'd0;
    if (!v.mis) begin
      for (int i = 0; i < nb; i++) val[8*i +: 8] = rdata[8*(off+i) +: 8];
      if (!f3[2] && nb < 8 && val[8*nb-1])
        for (int i = nb; i < 8; i++) val[8*i +: 8] = 8'hFF;
    end
    v.erd = (v.mis || we) ? prev_rd : val;
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    int stall_cnt, rv_cnt;
    @(negedge clk);
    mem_access = 1'b1; mem_we = v.we; func3 = v.f3; alu_result = v.addr; write_data = v.wd;
    #1;
    chk({tag, " misaligned"}, 64'(misal), 64'(v.mis));
    chk({tag, " stall_idle"}, 64'(stall), 64'(!v.mis));
    if (v.mis) begin
      @(negedge clk); #1;
      chk({tag, " no_req"}, 64'(dcif.dc_req_valid), 64'd0);
      chk({tag, " no_stall"}, 64'(stall), 64'd0);
      chk({tag, " rd_keep"}, read_data, v.erd);
      mem_access = 1'b0;
      return;
    end
    stall_cnt = 1; rv_cnt = 0;
    @(negedge clk);
    for (int i = 0; i <= v.rdy; i++) begin
      if (i == v.rdy) dcif.dc_req_ready = 1'b1;
      #1;
      rv_cnt    += int'(dcif.dc_req_valid);
      stall_cnt += int'(stall);
      chk({tag, " dc_addr"}, dcif.dc_addr, v.addr - (v.addr % 8));
      chk({tag, " dc_be"}, 64'(dcif.dc_byte_en), 64'(v.be));
      chk({tag, " dc_we"}, 64'(dcif.dc_we), 64'(v.we));
      if (v.we) chk({tag, " dc_wdata"}, dcif.dc_wdata, v.ewd);
      @(negedge clk);
    end
    dcif.dc_req_ready = 1'b0;
    for (int i = 0; i <= v.rsp; i++) begin
      if (i == v.rsp) begin dcif.dc_resp_valid = 1'b1; dcif.dc_rdata = v.rdata; end
      #1;
      stall_cnt += int'(stall);
      if (i == 0) chk({tag, " req_drop"}, 64'(dcif.dc_req_valid), 64'd0);
      @(negedge clk);
    end
    dcif.dc_resp_valid = 1'b0;
    dcif.dc_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
    #1;
    chk({tag, " stall_done"}, 64'(stall), 64'd0);
    chk({tag, " read_data"}, read_data, v.erd);
    chk({tag, " stall_cycles"}, 64'(stall_cnt), 64'(3 + v.rdy + v.rsp));
    chk({tag, " req_cycles"}, 64'(rv_cnt), 64'(v.rdy + 1));
    mem_access = 1'b0;
  endtask

  vec_t tbl[12];
  logic [63:0] prev_rd;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3'b000, 64'h1003, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 1'b0, 8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80};
    tbl[1]  = '{3'b100, 64'h1003, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 1, 2, 1'b0, 8'h08, 64'h0, 64'h0000_0000_0000_0080};
    tbl[2]  = '{3'b001, 64'h2006, 1'b1, 64'h1234, 64'h0, 0, 1, 1'b0, 8'hC0, 64'h1234_0000_0000_0000, 64'h80};
    tbl[3]  = '{3'b010, 64'h0002, 1'b0, 64'h0, 64'h0, 0, 0, 1'b1, 8'h00, 64'h0, 64'h80};
    tbl[4]  = '{3'b011, 64'h3000, 1'b0, 64'h0, 64'h0123_4567_89AB_CDEF, 5, 1, 1'b0, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF};
    tbl[5]  = '{3'b111, 64'h0000, 1'b0, 64'h0, 64'h0, 0, 0, 1'b1, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF};
    tbl[6]  = '{3'b001, 64'h4002, 1'b0, 64'h0, 64'h0000_0000_F00D_0000, 0, 0, 1'b0, 8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_F00D};
    tbl[7]  = '{3'b110, 64'h5004, 1'b0, 64'h0, 64'h8765_4321_0000_0000, 2, 0, 1'b0, 8'hF0, 64'h0, 64'h0000_0000_8765_4321};
    tbl[8]  = '{3'b010, 64'h5004, 1'b0, 64'h0, 64'h8765_4321_0000_0000, 0, 3, 1'b0, 8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321};
    tbl[9]  = '{3'b011, 64'h6008, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1, 1, 1'b0, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 64'hFFFF_FFFF_8765_4321};
    tbl[10] = '{3'b001, 64'h4003, 1'b0, 64'h0, 64'h0, 0, 0, 1'b1, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321};
    tbl[11] = '{3'b101, 64'h0010, 1'b0, 64'h0, 64'h0000_0000_0000_8001, 0, 0, 1'b0, 8'h03, 64'h0, 64'h0000_0000_0000_8001};

    arst = 1'b1; mem_access = 1'b0; mem_we = 1'b0; func3 = 3'b0; alu_result = '0; write_data = '0;
    dcif.dc_req_ready = 1'b0; dcif.dc_resp_valid = 1'b0; dcif.dc_rdata = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst read_data", read_data, 64'd0);
    chk("rst req_valid", 64'(dcif.dc_req_valid), 64'd0);
    chk("rst dc_addr", dcif.dc_addr, 64'd0);
    chk("rst dc_be", 64'(dcif.dc_byte_en), 64'd0);
    chk("rst dc_we_wdata", dcif.dc_wdata | 64'(dcif.dc_we), 64'd0);
    arst = 1'b0;

    for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Reset pulse while waiting for a load response; the late response must be ignored
    @(negedge clk);
    mem_access = 1'b1; mem_we = 1'b0; func3 = 3'b011; alu_result = 64'h7000;
    @(negedge clk); dcif.dc_req_ready = 1'b1;
    @(negedge clk); dcif.dc_req_ready = 1'b0; #1;
    chk("rstmid stall_wait", 64'(stall), 64'd1);
    mem_access = 1'b0;
    arst = 1'b1; #1;
    chk("rstmid read_data", read_data, 64'd0);
    chk("rstmid stall", 64'(stall), 64'd0);
    chk("rstmid req_valid", 64'(dcif.dc_req_valid), 64'd0);
    @(negedge clk); arst = 1'b0;
    dcif.dc_resp_valid = 1'b1; dcif.dc_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk); dcif.dc_resp_valid = 1'b0; #1;
    chk("rstmid late_resp", read_data, 64'd0);
    chk("rstmid idle_stall", 64'(stall), 64'd0);
    chk("rstmid idle_req", 64'(dcif.dc_req_valid), 64'd0);

    prev_rd = 64'd0;
    for (int n = 0; n < 60; n++) begin
      vec_t v;
      logic [2:0]  f3;
      logic [63:0] a;
      logic        we;
      f3 = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
      we = (f3[2] == 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
      v = model(f3, a, we, {$urandom, $urandom}, {$urandom, $urandom}, prev_rd);
      v.rdy = $urandom_range(0, 3);
      v.rsp = $urandom_range(0, 3);
      run(v, $sformatf("rnd%0d", n));
      prev_rd = v.erd;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
